// File: rtl/cpu_pkg.sv
// Shared definitions for the three-bus CPU control path: opcodes, ALU codes,
// sequencer states, decoded instruction classes and the control-strobe bundle.
package cpu_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  // The ALU understands the register-register opcodes directly.
  localparam logic [OPW-1:0] ALU_ADD = OP_ADD;
  localparam logic [OPW-1:0] ALU_AND = OP_AND;
  localparam logic [OPW-1:0] ALU_OR  = OP_OR;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_IMM,
    CLS_LDI,
    CLS_LD,
    CLS_ST,
    CLS_BR,
    CLS_JR,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } iclass_e;

  typedef struct packed {
    logic           pc_out;
    logic           zlow_out;
    logic           mdr_out;
    logic           c_out;
    logic           pc_in;
    logic           ir_in;
    logic           mar_in;
    logic           mdr_in;
    logic           y_in;
    logic           z_in;
    logic           con_in;
    logic           inc_pc;
    logic           gra;
    logic           grb;
    logic           grc;
    logic           r_in;
    logic           r_out;
    logic           ba_out;
    logic [OPW-1:0] alu_op;
    logic           read;
    logic           write;
  } ctrl_t;

  function automatic logic [OPW-1:0] imm_alu_op(input logic [OPW-1:0] opcode);
    case (opcode)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps IR[31:27] to an instruction class and the ALU code
// used by that class's arithmetic step.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [OPW-1:0] opcode_i,
  output iclass_e        cls_o,
  output logic [OPW-1:0] alu_op_o
);

  always_comb begin
    // NOTE: both outputs get a default before the case so every path assigns
    // them; leaving one unassigned on some path would infer a latch.
    cls_o    = CLS_ILLEGAL;
    alu_op_o = ALU_ADD;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        cls_o    = CLS_ALU;
        alu_op_o = opcode_i;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        cls_o    = CLS_IMM;
        alu_op_o = imm_alu_op(opcode_i);
      end
      OP_LDI:  cls_o = CLS_LDI;
      OP_LD:   cls_o = CLS_LD;
      OP_ST:   cls_o = CLS_ST;
      OP_BR:   cls_o = CLS_BR;
      OP_JR:   cls_o = CLS_JR;
      OP_NOP:  cls_o = CLS_NOP;
      OP_HALT: cls_o = CLS_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the three-bus datapath: one state per
// clock, Moore strobes except the br PC update and memory-wait advance.
module control_unit
  import cpu_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic [31:0]    ir,
  input  logic           con_ff,
  input  logic           mem_ready,
  input  logic           stop,
  output logic           PCout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           Cout,
  output logic           PCin,
  output logic           IRin,
  output logic           MARin,
  output logic           MDRin,
  output logic           Yin,
  output logic           Zin,
  output logic           CONin,
  output logic           IncPC,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic [OPW-1:0] alu_op,
  output logic           Read,
  output logic           Write,
  output logic           run,
  output logic           illegal
);

  state_e         state_q, state_d;
  iclass_e        cls;
  logic [OPW-1:0] cls_alu_op;
  ctrl_t          ctrl;
  logic           illegal_pulse;
  state_e         end_state;

  // Register fields are consumed by the select/encode logic, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir[26:0];

  ctrl_decode u_decode (
    .opcode_i (ir[31:27]),
    .cls_o    (cls),
    .alu_op_o (cls_alu_op)
  );

  // stop is only honoured on the final step of an instruction.
  assign end_state = stop ? S_HALT : S_T0;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values; reset is synchronous and only the state register needs it.
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ctrl          = '0;
    illegal_pulse = 1'b0;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
        state_d     = S_T1;
      end
      S_T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        state_d      = S_T3;
      end
      S_T3: begin
        state_d = S_T4;
        case (cls)
          CLS_ALU, CLS_IMM: begin
            ctrl.grb   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.y_in  = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            ctrl.grb    = 1'b1;
            ctrl.ba_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          CLS_BR: begin
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.con_in = 1'b1;
          end
          CLS_JR: begin
            ctrl.gra   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.pc_in = 1'b1;
            state_d    = end_state;
          end
          CLS_HALT: state_d = S_HALT;
          CLS_ILLEGAL: begin
            illegal_pulse = 1'b1;
            state_d       = end_state;
          end
          default: state_d = end_state;
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (cls)
          CLS_ALU: begin
            ctrl.grc    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.alu_op = cls_alu_op;
            ctrl.z_in   = 1'b1;
          end
          CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
            ctrl.c_out  = 1'b1;
            ctrl.alu_op = cls_alu_op;
            ctrl.z_in   = 1'b1;
          end
          CLS_BR: begin
            ctrl.pc_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        case (cls)
          CLS_ALU, CLS_IMM, CLS_LDI: begin
            ctrl.zlow_out = 1'b1;
            ctrl.gra      = 1'b1;
            ctrl.r_in     = 1'b1;
            state_d       = end_state;
          end
          CLS_LD, CLS_ST: begin
            ctrl.zlow_out = 1'b1;
            ctrl.mar_in   = 1'b1;
            state_d       = S_T6;
          end
          CLS_BR: begin
            ctrl.c_out  = 1'b1;
            ctrl.alu_op = cls_alu_op;
            ctrl.z_in   = 1'b1;
            state_d     = S_T6;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T6: begin
        case (cls)
          CLS_LD: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_in = 1'b1;
            if (mem_ready) state_d = S_T7;
          end
          CLS_ST: begin
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.mdr_in = 1'b1;
            state_d     = S_T7;
          end
          CLS_BR: begin
            ctrl.zlow_out = con_ff;
            ctrl.pc_in    = con_ff;
            state_d       = end_state;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T7: begin
        case (cls)
          CLS_LD: begin
            ctrl.mdr_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.r_in    = 1'b1;
            state_d      = end_state;
          end
          CLS_ST: begin
            ctrl.write = 1'b1;
            if (mem_ready) state_d = end_state;
          end
          default: state_d = S_T0;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  assign PCout   = ctrl.pc_out;
  assign Zlowout = ctrl.zlow_out;
  assign MDRout  = ctrl.mdr_out;
  assign Cout    = ctrl.c_out;
  assign PCin    = ctrl.pc_in;
  assign IRin    = ctrl.ir_in;
  assign MARin   = ctrl.mar_in;
  assign MDRin   = ctrl.mdr_in;
  assign Yin     = ctrl.y_in;
  assign Zin     = ctrl.z_in;
  assign CONin   = ctrl.con_in;
  assign IncPC   = ctrl.inc_pc;
  assign Gra     = ctrl.gra;
  assign Grb     = ctrl.grb;
  assign Grc     = ctrl.grc;
  assign Rin     = ctrl.r_in;
  assign Rout    = ctrl.r_out;
  assign BAout   = ctrl.ba_out;
  assign alu_op  = ctrl.alu_op;
  assign Read    = ctrl.read;
  assign Write   = ctrl.write;
  assign run     = (state_q != S_RESET) && (state_q != S_HALT);
  assign illegal = illegal_pulse;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: each instruction is expanded into its
// list of bus steps and compared cycle by cycle under randomized handshakes.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir = '0;
  logic        con_ff = 1'b0;
  logic        mem_ready = 1'b1;
  logic        stop = 1'b0;
  logic PCout, Zlowout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin, CONin;
  logic IncPC, Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, run, illegal;
  logic [4:0] alu_op;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .reset(reset), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
    .stop(stop), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .CONin(CONin), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .alu_op(alu_op), .Read(Read), .Write(Write),
    .run(run), .illegal(illegal)
  );

  logic [26:0] obs;
  assign obs = {PCout, Zlowout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin,
                CONin, IncPC, Gra, Grb, Grc, Rin, Rout, BAout, alu_op, Read, Write,
                run, illegal};

  localparam logic [26:0] B_PCOUT   = 27'd1 << 26;
  localparam logic [26:0] B_ZLOWOUT = 27'd1 << 25;
  localparam logic [26:0] B_MDROUT  = 27'd1 << 24;
  localparam logic [26:0] B_COUT    = 27'd1 << 23;
  localparam logic [26:0] B_PCIN    = 27'd1 << 22;
  localparam logic [26:0] B_IRIN    = 27'd1 << 21;
  localparam logic [26:0] B_MARIN   = 27'd1 << 20;
  localparam logic [26:0] B_MDRIN   = 27'd1 << 19;
  localparam logic [26:0] B_YIN     = 27'd1 << 18;
  localparam logic [26:0] B_ZIN     = 27'd1 << 17;
  localparam logic [26:0] B_CONIN   = 27'd1 << 16;
  localparam logic [26:0] B_INCPC   = 27'd1 << 15;
  localparam logic [26:0] B_GRA     = 27'd1 << 14;
  localparam logic [26:0] B_GRB     = 27'd1 << 13;
  localparam logic [26:0] B_GRC     = 27'd1 << 12;
  localparam logic [26:0] B_RIN     = 27'd1 << 11;
  localparam logic [26:0] B_ROUT    = 27'd1 << 10;
  localparam logic [26:0] B_BAOUT   = 27'd1 << 9;
  localparam logic [26:0] B_READ    = 27'd1 << 3;
  localparam logic [26:0] B_WRITE   = 27'd1 << 2;
  localparam logic [26:0] B_RUN     = 27'd1 << 1;
  localparam logic [26:0] B_ILL     = 27'd1;

  localparam logic [4:0] K_LD = 5'b00000, K_LDI = 5'b00001, K_ST = 5'b00010;
  localparam logic [4:0] K_ADD = 5'b00011, K_SUB = 5'b00100, K_AND = 5'b00101;
  localparam logic [4:0] K_OR = 5'b00110, K_ADDI = 5'b01100, K_ANDI = 5'b01101;
  localparam logic [4:0] K_ORI = 5'b01110, K_BR = 5'b10010, K_JR = 5'b10100;
  localparam logic [4:0] K_NOP = 5'b11010, K_HALT = 5'b11011;

  typedef struct {
    logic [26:0] outs;  // strobes for the step (br T6: the con_ff=1 version)
    bit          mem;   // step waits for mem_ready
    bit          brc;   // strobes gated by con_ff
  } step_t;

  step_t plan[$];

  function automatic logic [26:0] alu(input logic [4:0] code);
    return {18'd0, code, 4'd0};
  endfunction

  function automatic void push(input logic [26:0] o, input bit mem, input bit brc);
    step_t s;
    s.outs = o;
    s.mem  = mem;
    s.brc  = brc;
    plan.push_back(s);
  endfunction

  function automatic bit is_defined(input logic [4:0] op);
    return op inside {K_LD, K_LDI, K_ST, K_ADD, K_SUB, K_AND, K_OR, K_ADDI, K_ANDI,
                      K_ORI, K_BR, K_JR, K_NOP, K_HALT};
  endfunction

  // Cycles per instruction with memory always ready.
  function automatic int base_latency(input logic [4:0] op);
    if (op inside {K_ADD, K_SUB, K_AND, K_OR, K_ADDI, K_ANDI, K_ORI, K_LDI}) return 6;
    if (op inside {K_LD, K_ST}) return 8;
    if (op == K_BR) return 7;
    return 4;
  endfunction

  task automatic build_plan(input logic [4:0] op);
    logic [4:0] code;
    plan.delete();
    push(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 1'b0, 1'b0);
    push(B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN, 1'b1, 1'b0);
    push(B_MDROUT | B_IRIN, 1'b0, 1'b0);
    code = (op == K_ANDI) ? K_AND : (op == K_ORI) ? K_OR : K_ADD;
    if (op inside {K_ADD, K_SUB, K_AND, K_OR}) begin
      push(B_GRB | B_ROUT | B_YIN, 1'b0, 1'b0);
      push(B_GRC | B_ROUT | B_ZIN | alu(op), 1'b0, 1'b0);
      push(B_ZLOWOUT | B_GRA | B_RIN, 1'b0, 1'b0);
    end else if (op inside {K_ADDI, K_ANDI, K_ORI}) begin
      push(B_GRB | B_ROUT | B_YIN, 1'b0, 1'b0);
      push(B_COUT | B_ZIN | alu(code), 1'b0, 1'b0);
      push(B_ZLOWOUT | B_GRA | B_RIN, 1'b0, 1'b0);
    end else if (op inside {K_LDI, K_LD, K_ST}) begin
      push(B_GRB | B_BAOUT | B_YIN, 1'b0, 1'b0);
      push(B_COUT | B_ZIN | alu(K_ADD), 1'b0, 1'b0);
      if (op == K_LDI) begin
        push(B_ZLOWOUT | B_GRA | B_RIN, 1'b0, 1'b0);
      end else begin
        push(B_ZLOWOUT | B_MARIN, 1'b0, 1'b0);
        if (op == K_LD) begin
          push(B_READ | B_MDRIN, 1'b1, 1'b0);
          push(B_MDROUT | B_GRA | B_RIN, 1'b0, 1'b0);
        end else begin
          push(B_GRA | B_ROUT | B_MDRIN, 1'b0, 1'b0);
          push(B_WRITE, 1'b1, 1'b0);
        end
      end
    end else if (op == K_BR) begin
      push(B_GRA | B_ROUT | B_CONIN, 1'b0, 1'b0);
      push(B_PCOUT | B_YIN, 1'b0, 1'b0);
      push(B_COUT | B_ZIN | alu(K_ADD), 1'b0, 1'b0);
      push(B_ZLOWOUT | B_PCIN, 1'b0, 1'b1);
    end else if (op == K_JR) begin
      push(B_GRA | B_ROUT | B_PCIN, 1'b0, 1'b0);
    end else if (is_defined(op)) begin
      push('0, 1'b0, 1'b0);      // nop, halt
    end else begin
      push(B_ILL, 1'b0, 1'b0);
    end
  endtask

  task automatic drive_check(input string tag, input logic [26:0] expv, input bit mr,
                             input bit con, input bit stp);
    mem_ready = mr;
    con_ff    = con;
    stop      = stp;
    @(negedge clock);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive_check("reset_state", '0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic halt_check(input int n);
    for (int k = 0; k < n; k++)
      drive_check("halt_idle", '0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // stop_from: -1 never; otherwise stop is held from that step (clipped to the
  // last step). abort_step: memory step at which reset is applied mid-wait.
  task automatic exec_instr(input logic [4:0] op, input int w_fetch, input int w_exec,
                            input bit con, input int stop_from, input int abort_step,
                            output bit halted);
    int cycles, last, stop_idx, w, exp_lat;
    logic [26:0] e;
    bit stp;
    string tag;
    cycles = 0;
    halted = 1'b0;
    build_plan(op);
    last = plan.size() - 1;
    stop_idx = (stop_from < 0) ? -1 : ((stop_from > last) ? last : stop_from);
    ir = {op, 27'($urandom)};
    for (int i = 0; i <= last; i++) begin
      tag = $sformatf("op%05b_step%0d", op, i);
      if (stop_idx >= 0 && i >= stop_idx) stp = 1'b1;
      else if (i == last)                  stp = 1'b0;
      else                                 stp = 1'($urandom);
      e = plan[i].outs | B_RUN;
      if (plan[i].brc && !con) e = B_RUN;
      if (plan[i].mem && i == abort_step) begin
        drive_check({tag, "_wait"}, e, 1'b0, 1'($urandom), stp);
        reset = 1'b1;
        drive_check({tag, "_reset_edge"}, e, 1'b0, 1'($urandom), stp);
        reset = 1'b0;
        drive_check("reset_mid_wait", '0, 1'($urandom), 1'($urandom), 1'($urandom));
        return;
      end
      if (plan[i].mem) begin
        w = (i == 1) ? w_fetch : w_exec;
        for (int k = 0; k < w; k++) begin
          drive_check({tag, "_wait"}, e, 1'b0, 1'($urandom), stp);
          cycles++;
        end
        drive_check(tag, e, 1'b1, 1'($urandom), stp);
      end else begin
        drive_check(tag, e, 1'($urandom), plan[i].brc ? con : 1'($urandom), stp);
      end
      cycles++;
    end
    halted = (stop_idx >= 0) || (op == K_HALT);
    exp_lat = base_latency(op) + w_fetch + ((op == K_LD || op == K_ST) ? w_exec : 0);
    checks++;
    assert (cycles === exp_lat) else begin
      errors++;
      $error("FAIL latency_op%05b: observed=%0d expected=%0d", op, cycles, exp_lat);
    end
  endtask

  logic [4:0] ops [14] = '{K_LD, K_LDI, K_ST, K_ADD, K_SUB, K_AND, K_OR, K_ADDI,
                           K_ANDI, K_ORI, K_BR, K_JR, K_NOP, K_HALT};

  initial begin
    bit         h;
    logic [4:0] op;
    int         sf;

    do_reset();
    // Register ALU op, then ld with a 3-cycle memory wait.
    exec_instr(K_ADD, 0, 0, 1'b0, -1, -1, h);
    exec_instr(K_LD, 0, 3, 1'b0, -1, -1, h);
    // Branch not taken, then taken.
    exec_instr(K_BR, 0, 0, 1'b0, -1, -1, h);
    exec_instr(K_BR, 1, 0, 1'b1, -1, -1, h);
    exec_instr(5'b11111, 0, 0, 1'b0, -1, -1, h);
    exec_instr(K_ST, 2, 2, 1'b0, -1, -1, h);
    exec_instr(K_JR, 0, 0, 1'b0, -1, -1, h);
    // stop raised in T4 of sub: instruction completes, then the unit stays halted.
    exec_instr(K_SUB, 0, 0, 1'b0, 4, -1, h);
    halt_check(20);
    do_reset();
    // Reset during the ld data wait, then a clean fetch.
    exec_instr(K_LD, 0, 3, 1'b0, -1, 6, h);
    exec_instr(K_ADDI, 0, 0, 1'b0, -1, -1, h);
    exec_instr(K_HALT, 0, 0, 1'b0, -1, -1, h);
    halt_check(5);
    do_reset();

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 14) == 0) begin
        do op = 5'($urandom); while (is_defined(op));
      end else begin
        op = ops[$urandom_range(0, 13)];
      end
      sf = ($urandom_range(0, 9) == 0) ? 99 : -1;
      exec_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), sf, -1, h);
      if (h) begin
        halt_check(3);
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the 32-bit three-bus CPU datapath. Fetches each instruction through PC, MAR and MDR, then drives the register select/encode controls (Gra/Grb/Grc/Rin/Rout/BAout), bus-source and register-load strobes, ALU opcode and memory Read/Write, one step per clock. It sits beside the datapath, reads the IR and the CON flip-flop, and owns the run/halt status of the processor.

## Interface
- OPW, 5, opcode field width (IR[31:27])
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; forces state RESET
- ir  in  32  current IR contents: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0]
- con_ff  in  1  branch-condition flip-flop output
- mem_ready  in  1  memory completes the current Read/Write this cycle
- stop  in  1  halt request, honoured at instruction boundary
- PCout, Zlowout, MDRout, Cout  out  1 each  bus-source enables
- PCin, IRin, MARin, MDRin, Yin, Zin, CONin  out  1 each  register load enables
- IncPC  out  1  ALU computes PC+1
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  to select/encode logic
- alu_op  out  OPW  ALU operation code
- Read, Write  out  1 each  memory strobes
- run  out  1  high while executing, low in HALT/RESET
- illegal  out  1  one-cycle pulse on undefined opcode

## Operation
- Every output is 0 in RESET; all strobes default 0 in every state unless listed.
- RESET -> T0 unconditionally (run rises entering T0).
- Fetch, all opcodes: T0 PCout, MARin, IncPC, Zin. T1 Zlowout, PCin, Read, MDRin. T2 MDRout, IRin. T3 decodes ir.
- add/sub/and/or: T3 Grb, Rout, Yin; T4 Grc, Rout, alu_op=opcode, Zin; T5 Zlowout, Gra, Rin.
- addi/andi/ori: T3 Grb, Rout, Yin; T4 Cout, alu_op=ADD/AND/OR, Zin; T5 Zlowout, Gra, Rin.
- ldi: T3 Grb, BAout, Yin; T4 Cout, alu_op=ADD, Zin; T5 Zlowout, Gra, Rin.
- ld: as ldi T3-T4; T5 Zlowout, MARin; T6 Read, MDRin; T7 MDRout, Gra, Rin.
- st: as ld T3-T5; T6 Gra, Rout, MDRin; T7 Write.
- br: T3 Gra, Rout, CONin; T4 PCout, Yin; T5 Cout, alu_op=ADD, Zin; T6 Zlowout and PCin only if con_ff=1.
- jr: T3 Gra, Rout, PCin.
- nop: T3 no strobes. halt: T3 -> HALT.
- Last step of every instruction -> T0, or -> HALT if stop=1 sampled in that step.
- Undefined opcode: T3 pulses illegal, executes as nop.
- HALT: run=0, all strobes 0; exits only via reset.

## Timing
- Every state lasts one cycle except memory states T1 (fetch), ld T6, st T7.
- Memory wait: Read (with MDRin) or Write held while mem_ready=0; state advances on the cycle mem_ready=1. MDR reloads every held cycle; the value from the mem_ready=1 cycle is final.
- Instruction latency with mem_ready tied high: ALU/immediate/ldi 6 cycles, ld/st 8, br 7, jr/nop 4.
- Read and Write are never asserted together.
- Reset during any state, including a memory wait: next cycle is RESET, all outputs 0, Read/Write dropped.
- stop asserted mid-instruction is ignored until the final step; stop deasserted before that step has no effect.
- Outputs are Moore (state-decoded), except T6 of br, which depends on con_ff, and memory-wait advance, which depends on mem_ready.

## Structure
- Shared package cpu_pkg: opcode localparams (ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, br 10010, jr 10100, nop 11010, halt 11011); state encoding (RESET, T0-T7, HALT); alu_op codes.
- Sub-module ctrl_decode: combinational opcode -> instruction class (ALU, IMM, LDI, LD, ST, BR, JR, NOP, HALT, ILLEGAL). control_unit holds the state register and output decoding.

## Test plan
- Reset then add R1,R2,R3 (opcode 00011, Ra=1, Rb=2, Rc=3), mem_ready=1 -> fetch strobes T0-T2; T3 Grb+Rout+Yin; T4 Grc+Rout, alu_op=00011; T5 Gra+Rin; back in T0 at cycle 7.
- ld R4, 0x10(R0) with mem_ready low 3 cycles in T6 -> Read+MDRin held 4 cycles; T7 MDRout+Gra+Rin; total 11 cycles.
- br with con_ff=0 then con_ff=1 -> PCin absent in T6 for the first, Zlowout+PCin in T6 for the second.
- Opcode 11111 -> illegal high exactly in T3 for one cycle; no register strobes; next state T0.
- stop raised during T4 of sub -> instruction completes through T5; HALT; run=0; all strobes 0 for 20 cycles.
- reset asserted during ld T6 wait -> next cycle Read=0, all outputs 0; fetch restarts at T0.
